// File: rtl/h_pkg.sv
// Shared types for the h hash-table engine and its command arbiter.
package h_pkg;

   typedef enum logic [1:0] {
      OP_NOP    = 2'd0,
      OP_INSERT = 2'd1,
      OP_LOOKUP = 2'd2,
      OP_DELETE = 2'd3
   } opcode_t;

   typedef logic [15:0] k_t;
   typedef logic [31:0] v_t;

   typedef enum logic [1:0] {
      STATUS_OK      = 2'd0,
      STATUS_MISS    = 2'd1,
      STATUS_FULL    = 2'd2,
      STATUS_TIMEOUT = 2'd3
   } status_t;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } h_cmd_arb_state_t;

endpackage

// File: rtl/h_rr_arb.sv
// N-way round-robin arbiter: search starts at ptr, first set request wins (one-hot grant).
module h_rr_arb #(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant
);

   int unsigned idx;
   logic        found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = (32'(ptr) + i) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/h_cmd_arb.sv
// Round-robin sharing of the h engine between N requesters, one command in flight.
// Optional watchdog: define H_CMD_ARB_WATCHDOG_EN (adds o_timeout and a TIMEOUT-cycle limit).
module h_cmd_arb
   import h_pkg::*;
#(
   parameter int unsigned N       = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              arst_n,
`ifdef H_CMD_ARB_WATCHDOG_EN
   output logic              o_timeout,
`endif
   input  logic [N-1:0]      req_vld,
   output logic [N-1:0]      req_rdy,
   input  opcode_t [N-1:0]   req_opcode,
   input  k_t [N-1:0]        req_k,
   input  v_t [N-1:0]        req_v,
   output logic [N-1:0]      up_rsp_vld,
   output status_t           up_rsp_status,
   output v_t                up_rsp_v,
   output logic              cmd_vld,
   output opcode_t           cmd_opcode,
   output k_t                cmd_k,
   output v_t                cmd_v,
   input  logic              rsp_vld,
   input  status_t           rsp_status,
   input  v_t                rsp_v
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   if (N < 2 || N > 16 || TIMEOUT < 1) begin : g_bad_cfg
      $error("h_cmd_arb: N must be 2..16 and TIMEOUT at least 1");
   end

   h_cmd_arb_state_t state;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    id;
   logic [IW-1:0]    win_idx;
   logic [N-1:0]     grant;
   logic             accept;
   logic [N-1:0]     id_onehot;

`ifdef H_CMD_ARB_WATCHDOG_EN
   localparam int unsigned WDW = $clog2(TIMEOUT + 1);
   logic [WDW-1:0] wd_cnt;
`endif

   h_rr_arb #(.N(N)) u_rr_arb (
      .req   (req_vld),
      .ptr   (ptr),
      .grant (grant)
   );

   // Gated by arst_n so req_rdy also reads zero while reset is held.
   assign req_rdy   = (state == IDLE && arst_n) ? grant : '0;
   assign accept    = |(req_vld & req_rdy);
   assign id_onehot = {{(N-1){1'b0}}, 1'b1} << id;

   always_comb begin
      win_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant[i]) win_idx = IW'(i);
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state         <= IDLE;
         ptr           <= '0;
         id            <= '0;
         cmd_vld       <= 1'b0;
         cmd_opcode    <= OP_NOP;
         cmd_k         <= '0;
         cmd_v         <= '0;
         up_rsp_vld    <= '0;
         up_rsp_status <= STATUS_OK;
         up_rsp_v      <= '0;
`ifdef H_CMD_ARB_WATCHDOG_EN
         wd_cnt        <= '0;
         o_timeout     <= 1'b0;
`endif
      end else begin
         cmd_vld    <= 1'b0;
         up_rsp_vld <= '0;
`ifdef H_CMD_ARB_WATCHDOG_EN
         o_timeout  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (accept) begin
                  state      <= WAIT;
                  cmd_vld    <= 1'b1;
                  cmd_opcode <= req_opcode[win_idx];
                  cmd_k      <= req_k[win_idx];
                  cmd_v      <= req_v[win_idx];
                  id         <= win_idx;
                  ptr        <= (32'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
`ifdef H_CMD_ARB_WATCHDOG_EN
                  wd_cnt     <= '0;
`endif
               end
            end
            WAIT: begin
               if (rsp_vld) begin
                  state         <= IDLE;
                  up_rsp_vld    <= id_onehot;
                  up_rsp_status <= rsp_status;
                  up_rsp_v      <= rsp_v;
               end
`ifdef H_CMD_ARB_WATCHDOG_EN
               // A response arriving on the expiry cycle still wins over the timeout.
               else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
                  state         <= IDLE;
                  up_rsp_vld    <= id_onehot;
                  up_rsp_status <= STATUS_TIMEOUT;
                  up_rsp_v      <= '0;
                  o_timeout     <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef H_CMD_ARB_WATCHDOG_EN
   a_no_stale_rsp: assert property (@(posedge clk) disable iff (!arst_n) rsp_vld |-> state == WAIT)
      else $warning("h_cmd_arb: h response with no command in flight, dropped");
`endif

endmodule
